// File: rtl/tlb_assoc.sv
// Fully-associative L1 TLB: single-cycle registered lookup, 4K/2M/1G pages, one PTW refill in flight,
// SFENCE.VMA flush. Replacement is round-robin by default; define TLB_PLRU_EN for tree pseudo-LRU.
module tlb_assoc #(
  parameter int ENTRIES     = 8,
  parameter int VADDR_W     = 39,
  parameter int PADDR_W     = 56,
  parameter int PG_IDX_BITS = 12,
  parameter int PG_LEVELS   = 3,
  parameter int LEVEL_BITS  = 9
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           i_vm_enable,
  input  logic [1:0]                     i_priv,
  input  logic                           i_req_valid,
  input  logic [VADDR_W-1:0]             i_req_vaddr,
  input  logic                           i_req_store,
  output logic                           o_resp_valid,
  output logic                           o_resp_miss,
  output logic                           o_resp_pf,
  output logic [PADDR_W-1:0]             o_resp_paddr,
  output logic                           o_ptw_req_valid,
  input  logic                           i_ptw_req_ready,
  output logic [VADDR_W-PG_IDX_BITS-1:0] o_ptw_req_vpn,
  input  logic                           i_ptw_resp_valid,
  input  logic                           i_ptw_resp_pf,
  input  logic [PADDR_W-PG_IDX_BITS-1:0] i_ptw_resp_ppn,
  input  logic [1:0]                     i_ptw_resp_level,
  input  logic [5:0]                     i_ptw_resp_perm,
  input  logic                           i_sfence_valid,
  input  logic                           i_sfence_addr_en,
  input  logic [VADDR_W-1:0]             i_sfence_vaddr
);
  localparam int VPN_W = VADDR_W - PG_IDX_BITS;
  localparam int PPN_W = PADDR_W - PG_IDX_BITS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int P_R = 0, P_W = 1, P_U = 3, P_A = 4, P_D = 5;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [ENTRIES-1:0] ent_valid;
  logic [VPN_W-1:0]   ent_vpn   [ENTRIES];
  logic [PPN_W-1:0]   ent_ppn   [ENTRIES];
  logic [1:0]         ent_level [ENTRIES];
  logic [5:0]         ent_perm  [ENTRIES];
  logic [VPN_W-1:0]   ent_mask  [ENTRIES];

  // Ones over the VPN fields that take part in a match for a leaf at this level.
  function automatic logic [VPN_W-1:0] level_mask(input logic [1:0] level);
    logic [VPN_W-1:0] m;
    m = '1;
    for (int j = 0; j < PG_LEVELS; j++)
      if (j < int'(level)) m[j*LEVEL_BITS +: LEVEL_BITS] = '0;
    return m;
  endfunction

  logic                 vm_on, hit, perm_fault, any_free, fill_en, drop_q;
  logic [VPN_W-1:0]     req_vpn, sf_vpn, walk_vpn;
  logic [ENTRIES-1:0]   hit_vec, flush_vec;
  logic [PPN_W-1:0]     hit_ppn;
  logic [5:0]           hit_perm;
  logic [IDX_W-1:0]     hit_idx, free_idx, repl_idx, victim;
  logic                 unused_bits;

  assign unused_bits = ^{i_sfence_vaddr[PG_IDX_BITS-1:0], hit_perm[2]};

  // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
  //       every variable gets a default up front, so no path can leave it unassigned (no latch).
  always_comb begin
    vm_on    = i_vm_enable && (i_priv != 2'd3);
    req_vpn  = i_req_vaddr[VADDR_W-1:PG_IDX_BITS];
    sf_vpn   = i_sfence_vaddr[VADDR_W-1:PG_IDX_BITS];
    hit_vec  = '0;
    flush_vec = '0;
    hit_ppn  = '0;
    hit_perm = '0;
    hit_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ent_mask[i]  = level_mask(ent_level[i]);
      hit_vec[i]   = ent_valid[i] && (((ent_vpn[i] ^ req_vpn) & ent_mask[i]) == '0);
      flush_vec[i] = ent_valid[i] &&
                     (!i_sfence_addr_en || (((ent_vpn[i] ^ sf_vpn) & ent_mask[i]) == '0));
      // At most one entry can hit, so the result fields are simply OR-merged.
      if (hit_vec[i]) begin
        hit_ppn  |= {ent_ppn[i][PPN_W-1:VPN_W],
                     (ent_ppn[i][VPN_W-1:0] & ent_mask[i]) | (req_vpn & ~ent_mask[i])};
        hit_perm |= ent_perm[i];
        hit_idx  |= IDX_W'(i);
      end
    end
    hit = |hit_vec;
  end

  always_comb begin
    perm_fault = !hit_perm[P_A];
    if (i_req_store) perm_fault = perm_fault || !(hit_perm[P_W] && hit_perm[P_D]);
    else             perm_fault = perm_fault || !hit_perm[P_R];
    if (i_priv == 2'd0) perm_fault = perm_fault || !hit_perm[P_U];
    else                perm_fault = perm_fault ||  hit_perm[P_U];
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_resp_valid <= 1'b0;
      o_resp_miss  <= 1'b0;
      o_resp_pf    <= 1'b0;
      o_resp_paddr <= '0;
    end else begin
      o_resp_valid <= i_req_valid;
      o_resp_miss  <= i_req_valid && vm_on && !hit;
      o_resp_pf    <= i_req_valid && vm_on && hit && perm_fault;
      if (!i_req_valid)  o_resp_paddr <= '0;
      else if (!vm_on)   o_resp_paddr <= PADDR_W'(i_req_vaddr);
      else if (hit)      o_resp_paddr <= {hit_ppn, i_req_vaddr[PG_IDX_BITS-1:0]};
      else               o_resp_paddr <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_req_valid && vm_on && !hit) state_d = S_REQ;
      S_REQ:   if (i_ptw_req_ready)              state_d = S_WAIT;
      S_WAIT:  if (i_ptw_resp_valid)             state_d = S_IDLE;
      default:                                   state_d = S_IDLE;
    endcase
  end

  always_comb o_ptw_req_valid = (state_q == S_REQ);
  assign o_ptw_req_vpn = walk_vpn;

  // A flush seen while a walk is outstanding makes its result stale; a coincident flush beats the fill.
  assign fill_en = (state_q == S_WAIT) && i_ptw_resp_valid && !i_ptw_resp_pf && !drop_q && !i_sfence_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walk_vpn <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && state_d == S_REQ) walk_vpn <= req_vpn;
      if (state_q == S_IDLE)   drop_q <= 1'b0;
      else if (i_sfence_valid) drop_q <= 1'b1;
    end
  end

  always_comb begin
    any_free = ~&ent_valid;
    free_idx = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!ent_valid[i]) free_idx = IDX_W'(i);
    victim = any_free ? free_idx : repl_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            ent_valid <= '0;
    else if (i_sfence_valid) ent_valid <= ent_valid & ~flush_vec;
    else if (fill_en)        ent_valid[victim] <= 1'b1;
  end

  // NOTE: the payload arrays carry no reset; an entry's contents are only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      ent_vpn[victim]   <= walk_vpn;
      ent_ppn[victim]   <= i_ptw_resp_ppn;
      ent_level[victim] <= i_ptw_resp_level;
      ent_perm[victim]  <= i_ptw_resp_perm;
    end
  end

`ifdef TLB_PLRU_EN
  // Heap-ordered tree: node n has children 2n and 2n+1; a set bit means the LRU side is the right child.
  logic [ENTRIES-1:0] plru_q, plru_d;

  function automatic logic [ENTRIES-1:0] plru_touch(input logic [ENTRIES-1:0] t, input logic [IDX_W-1:0] idx);
    logic [IDX_W:0]   node;
    logic [IDX_W-1:0] path;
    logic             dir;
    node = (IDX_W+1)'(1);
    path = idx;
    for (int d = 0; d < IDX_W; d++) begin
      dir = path[IDX_W-1];
      t[node[IDX_W-1:0]] = ~dir;
      node = {node[IDX_W-1:0], dir};
      path = path << 1;
    end
    return t;
  endfunction

  always_comb begin
    logic [IDX_W:0] node;
    plru_d = plru_q;
    if (i_req_valid && vm_on && hit) plru_d = plru_touch(plru_d, hit_idx);
    if (fill_en)                     plru_d = plru_touch(plru_d, victim);
    node = (IDX_W+1)'(1);
    for (int d = 0; d < IDX_W; d++) node = {node[IDX_W-1:0], plru_q[node[IDX_W-1:0]]};
    repl_idx = node[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) plru_q <= '0;
    else          plru_q <= plru_d;
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= '0;
    else if (fill_en && !any_free)
      rr_ptr <= (rr_ptr == IDX_W'(ENTRIES-1)) ? '0 : rr_ptr + 1'b1;
  end

  assign repl_idx = rr_ptr;
`endif

endmodule
